sccb_master: RTL and testbench
==============================

Name: sccb_master

Overview:
- Serial Camera Control Bus (SCCB) master. It sits directly downstream of the OV7670 camera driver.
- Accepts one command pulse carrying device address, sub-address, data and mode.
- Executes the corresponding OV7670 SCCB 3-phase write, 2-phase write or 2-phase read on SIO_C/SIO_D.
- Reports busy, completion, the read byte and ack-slot status back to the driver.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency.
SCCB_FREQ_HZ, 100000, SIO_C bit rate. QTR = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) clocks per quarter-bit; elaboration error if QTR < 1.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_  in  1  synchronous reset, active-high (asserted = 1).
i_usher  in  1  command strobe; one-cycle pulse.
i_address  in  8  device address; bit 0 ignored, block forces R/W bit.
i_subaddress  in  8  register sub-address.
i_data  in  8  write data.
i_mode  in  2  00 = 3-phase write, 01 = 2-phase write (sub-address only), 10 = read, 11 = reserved.
o_busy  out  1  command in progress.
o_done  out  1  one-cycle pulse at command completion.
o_data  out  8  last byte read.
o_nack  out  1  1 if any write-phase ack slot sampled high in the last command.
sio_c  out  1  SCCB clock.
sio_d_o  out  1  SIO_D drive value.
sio_d_oe  out  1  1 = drive sio_d_o; 0 = release (external pull-up).
sio_d_i  in  1  SIO_D sampled value.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_data=0x00, o_nack=0, sio_c=1, sio_d_o=1, sio_d_oe=0; FSM to IDLE; quarter counter to 0.
- Reset mid-transfer: abort immediately to reset values. No STOP is generated.
- Accept: in IDLE, i_usher=1 with i_mode≠11 latches all inputs and clears o_nack. o_busy=1 from the next cycle.
- Ignored: i_usher while busy, and i_usher with mode 11. Neither has any effect.
- FSM states: IDLE, START, BYTE, STOP, GAP, DONE. A quarter tick occurs every QTR clocks; each START/bit/STOP/GAP element lasts 4 quarters (q0..q3).
- START: q0 d=1 c=1; q1–q2 d=0 c=1; q3 d=0 c=0.
- Bit:
  - q0: c=0, set d.
  - q1–q2: c=1.
  - q3: c=0.
  - Sampling of sio_d_i happens on the last clock of q1.
- STOP: q0 c=0 d=0; q1 c=1 d=0; q2–q3 c=1 d=1. Leaves the bus with sio_c=1 and sio_d_oe=0.
- GAP: 4 quarters, c=1, d released.
- Bytes: 8 data bits MSB first, then a 9th slot.
  - Write byte: 9th slot released; sampled high sets o_nack (sticky within the command).
  - Read byte: data bits released and shifted in MSB first; 9th slot driven 1 (master NA).
- Mode 00 sequence: START, {addr[7:1],0}, sub, data, STOP = 116 quarters.
- Mode 01 sequence: START, {addr[7:1],0}, sub, STOP = 80 quarters.
- Mode 10 sequence:
  - START, {addr[7:1],0}, sub, STOP, GAP.
  - START, {addr[7:1],1}, read byte, STOP.
  - Total 164 quarters.
- DONE: one cycle with o_done=1 and o_busy=0; then IDLE. A new i_usher is accepted in the DONE cycle or later.
- o_data: updated only in DONE of a read; holds otherwise.
- Ack-slot sampling: the 9th slot of the read-address byte is also sampled into o_nack.
- Latency: accept to o_done = quarters*QTR + 1 clocks. Sub-address and data are taken only from the latched copies; input changes after accept have no effect.

Test Plan:
- Write path (QTR=2): mode 00, addr 0x42, sub 0x12, data 0x80, slave acks low → SIO_D bytes 0x42, 0x12, 0x80 with correct START/STOP; o_done exactly 233 clocks after accept; o_nack=0; o_busy high for 232 cycles.
- Read path (QTR=2): mode 10, sub 0x0A, bench slave returns 0x76 → bytes 0x42, 0x0A, STOP, GAP, START, 0x43; master NA=1; o_data=0x76 at o_done, 329 clocks after accept.
- NACK reporting: mode 01, sub 0x1C, slave leaves SIO_D high on ack slots → o_nack=1 at o_done (161 clocks after accept at QTR=2). The next good command clears it to 0.
- Ignored commands: i_usher pulsed mid-transfer, and a mode 11 strobe in IDLE → no extra transaction; o_busy unchanged; sio lines idle for the mode 11 case.
- Reset mid-operation: assert reset_ during the 5th bit of the sub-address → next cycle sio_c=1, sio_d_oe=0, o_busy=0, o_data retains 0x00. A fresh mode 00 command then completes normally.
- Back-to-back: i_usher in the DONE cycle of a previous write → accepted; START begins with no lost cycles; both o_done pulses observed.

Source files
------------

// File: rtl/sccb_master_if.sv
// Command/status handshake between the camera driver and the SCCB master,
// plus the SIO_C/SIO_D pin-level signals.
interface sccb_master_if;
    logic       i_usher;
    logic [7:0] i_address;
    logic [7:0] i_subaddress;
    logic [7:0] i_data;
    logic [1:0] i_mode;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_data;
    logic       o_nack;
    logic       sio_c;
    logic       sio_d_o;
    logic       sio_d_oe;
    logic       sio_d_i;

    modport master (
        input  i_usher, i_address, i_subaddress, i_data, i_mode, sio_d_i,
        output o_busy, o_done, o_data, o_nack, sio_c, sio_d_o, sio_d_oe
    );

    modport slave (
        output i_usher, i_address, i_subaddress, i_data, i_mode, sio_d_i,
        input  o_busy, o_done, o_data, o_nack, sio_c, sio_d_o, sio_d_oe
    );
endinterface

// File: rtl/sccb_master.sv
// OV7670 SCCB master: 3-phase write, 2-phase write and 2-phase read built
// from quarter-bit timed START / bit / STOP / GAP elements.
module sccb_master #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SCCB_FREQ_HZ = 100_000
) (
    input  logic         clk,
    input  logic         reset_,
    sccb_master_if.master bus
);
    localparam int QTR   = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int CNT_W = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CNT_W-1:0] QTR_M1 = CNT_W'(QTR - 1);

    if (QTR < 1) begin : g_bad_qtr
        $error("sccb_master: CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) must be at least 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_STOP, S_GAP, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] qcnt;
    logic [1:0]       q;
    logic [3:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic             seg;
    logic             nack;
    logic [7:0]       data_out;
    logic [7:0]       addr_r, sub_r, data_r, rx_sr, tx_byte;
    logic [1:0]       mode_r;

    logic accept, tick, elem_end, last_bit, last_byte, rd_byte, busy_st, sample, tx_bit;

    assign accept    = bus.i_usher && (bus.i_mode != 2'b11) &&
                       ((state == S_IDLE) || (state == S_DONE));
    assign busy_st   = (state != S_IDLE) && (state != S_DONE);
    assign tick      = (qcnt == QTR_M1);
    assign elem_end  = tick && (q == 2'd3);
    assign last_bit  = (bit_idx == 4'd8);
    // The first segment carries a data byte only for the 3-phase write
    assign last_byte = (byte_idx == ((!seg && (mode_r == 2'b00)) ? 2'd2 : 2'd1));
    assign rd_byte   = seg && (byte_idx == 2'd1);
    assign sample    = (state == S_BYTE) && tick && (q == 2'd1);

    always_comb begin
        tx_byte = {addr_r[7:1], seg};
        if (byte_idx == 2'd1)
            tx_byte = sub_r;
        else if (byte_idx == 2'd2)
            tx_byte = data_r;
    end
    assign tx_bit = tx_byte[~bit_idx[2:0]];

    always_ff @(posedge clk) begin
        if (reset_)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: if (elem_end) state_nxt = S_BYTE;
            S_BYTE:  if (elem_end && last_bit && last_byte) state_nxt = S_STOP;
            S_STOP:  if (elem_end) state_nxt = ((mode_r == 2'b10) && !seg) ? S_GAP : S_DONE;
            S_GAP:   if (elem_end) state_nxt = S_START;
            S_DONE:  state_nxt = accept ? S_START : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.sio_c    = 1'b1;
        bus.sio_d_o  = 1'b1;
        bus.sio_d_oe = 1'b0;
        bus.o_busy   = busy_st;
        bus.o_done   = (state == S_DONE);
        case (state)
            S_START: begin
                bus.sio_d_oe = 1'b1;
                bus.sio_c    = (q != 2'd3);
                bus.sio_d_o  = (q == 2'd0);
            end
            S_BYTE: begin
                bus.sio_c = (q == 2'd1) || (q == 2'd2);
                // Write bytes release the 9th slot; read bytes release data and drive NA
                if (last_bit) begin
                    bus.sio_d_oe = rd_byte;
                    bus.sio_d_o  = 1'b1;
                end else begin
                    bus.sio_d_oe = !rd_byte;
                    bus.sio_d_o  = rd_byte ? 1'b1 : tx_bit;
                end
            end
            S_STOP: begin
                bus.sio_d_oe = 1'b1;
                bus.sio_c    = (q != 2'd0);
                bus.sio_d_o  = q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            qcnt     <= '0;
            q        <= 2'd0;
            bit_idx  <= 4'd0;
            byte_idx <= 2'd0;
            seg      <= 1'b0;
            nack     <= 1'b0;
            data_out <= 8'h00;
        end else if (accept) begin
            qcnt     <= '0;
            q        <= 2'd0;
            bit_idx  <= 4'd0;
            byte_idx <= 2'd0;
            seg      <= 1'b0;
            nack     <= 1'b0;
        end else begin
            if (busy_st) begin
                qcnt <= tick ? '0 : qcnt + CNT_W'(1);
                if (tick)
                    q <= q + 2'd1;
            end
            if (elem_end) begin
                case (state)
                    S_START: bit_idx <= 4'd0;
                    S_BYTE: begin
                        if (last_bit) begin
                            bit_idx  <= 4'd0;
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    S_GAP: begin
                        seg      <= 1'b1;
                        byte_idx <= 2'd0;
                    end
                    default: ;
                endcase
            end
            if (sample && last_bit && !rd_byte && bus.sio_d_i)
                nack <= 1'b1;
            // Publish the read byte so it is already valid in the DONE cycle
            if ((state == S_STOP) && (state_nxt == S_DONE) && (mode_r == 2'b10))
                data_out <= rx_sr;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_r <= bus.i_address;
            sub_r  <= bus.i_subaddress;
            data_r <= bus.i_data;
            mode_r <= bus.i_mode;
        end
        if (sample && rd_byte && !last_bit)
            rx_sr <= {rx_sr[6:0], bus.sio_d_i};
    end

    assign bus.o_data = data_out;
    assign bus.o_nack = nack;
endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: a bus-level SCCB slave/decoder plus a transaction
// model that predicts byte streams, timing, ack status and read data.
module tb_sccb_master;
    localparam int QTR = 2;
    localparam int EV_START = 256;
    localparam int EV_STOP  = 257;

    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    sccb_master_if ifc();
    logic slave_low = 1'b0;
    assign ifc.sio_d_i = (ifc.sio_d_oe ? ifc.sio_d_o : 1'b1) & ~slave_low;

    sccb_master #(.CLK_FREQ_HZ(800_000), .SCCB_FREQ_HZ(100_000)) dut (
        .clk(clk), .reset_(reset_), .bus(ifc)
    );

    int checks = 0;
    int errors = 0;
    int ev_q[$];
    int exp_q[$];
    logic [7:0] rd_val = 8'h00;
    logic [2:0] ack_mask = 3'b000;
    int ack_k = 0;
    int proto_err = 0;
    logic [7:0] model_odata;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] addr, sub, data, rdval;
        logic [2:0] mask;
        int         exp_lat;
        logic       exp_nack;
        logic [7:0] exp_odata;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus decoder and slave: logs START/STOP/bytes, answers ack slots and read data
    initial begin : monitor
        logic pc, pd, c, d, skip, in_txn, rd_txn;
        logic [7:0] cur;
        int nbit, nbyte;
        pc = 1'b1; pd = 1'b1; skip = 1'b0; in_txn = 1'b0; rd_txn = 1'b0;
        cur = 8'h00; nbit = 0; nbyte = 0;
        forever begin
            @(negedge clk);
            c = ifc.sio_c;
            d = ifc.sio_d_i;
            if (c && pc && pd && !d) begin
                ev_q.push_back(EV_START);
                in_txn = 1'b1; nbit = 0; nbyte = 0; skip = 1'b1; rd_txn = 1'b0;
                slave_low = 1'b0;
            end else if (c && pc && !pd && d) begin
                ev_q.push_back(EV_STOP);
                in_txn = 1'b0; slave_low = 1'b0;
            end else if (!pc && c && in_txn) begin
                if (nbit < 8) begin
                    cur = {cur[6:0], d};
                    if (rd_txn && nbyte == 1 && ifc.sio_d_oe) proto_err++;
                end else if (rd_txn && nbyte == 1) begin
                    if (!(ifc.sio_d_oe && ifc.sio_d_o)) proto_err++;
                end else if (ifc.sio_d_oe) begin
                    proto_err++;
                end
            end else if (pc && !c && in_txn) begin
                if (skip) skip = 1'b0;
                else begin
                    nbit++;
                    if (nbit == 9) begin
                        ev_q.push_back(int'(cur));
                        if (nbyte == 0) rd_txn = cur[0];
                        nbit = 0;
                        nbyte++;
                    end
                end
                slave_low = 1'b0;
                if (rd_txn && nbyte == 1) begin
                    if (nbit < 8) slave_low = !rd_val[7-nbit];
                end else if (nbit == 8) begin
                    if (ack_k < 3) slave_low = !ack_mask[ack_k];
                    ack_k++;
                end
            end
            pc = c;
            pd = ifc.sio_d_i;
        end
    end

    // Transaction model: element counts give quarters, byte list gives the bus stream
    function automatic int model_lat(input logic [1:0] m);
        int elems;
        case (m)
            2'b00:   elems = 1 + 3 * 9 + 1;
            2'b01:   elems = 1 + 2 * 9 + 1;
            default: elems = (1 + 2 * 9 + 1) + 1 + (1 + 2 * 9 + 1);
        endcase
        return elems * 4 * QTR + 1;
    endfunction

    function automatic void model_events(input logic [1:0] m, input logic [7:0] a, s, dt, rv);
        exp_q.delete();
        exp_q.push_back(EV_START);
        exp_q.push_back(int'({a[7:1], 1'b0}));
        exp_q.push_back(int'(s));
        if (m == 2'b00) exp_q.push_back(int'(dt));
        exp_q.push_back(EV_STOP);
        if (m == 2'b10) begin
            exp_q.push_back(EV_START);
            exp_q.push_back(int'({a[7:1], 1'b1}));
            exp_q.push_back(int'(rv));
            exp_q.push_back(EV_STOP);
        end
    endfunction

    task automatic start_cmd(input logic [1:0] m, input logic [7:0] a, s, dt, rv, input logic [2:0] mk);
        ev_q.delete();
        ack_k = 0; proto_err = 0; rd_val = rv; ack_mask = mk;
        ifc.i_mode = m; ifc.i_address = a; ifc.i_subaddress = s; ifc.i_data = dt;
        ifc.i_usher = 1'b1;
        @(negedge clk);
        ifc.i_usher = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input int poke, input int exp_lat,
                              input logic exp_nack, input logic [7:0] exp_od,
                              input logic [1:0] m, input logic [7:0] a, s, dt, rv);
        int k, lat, bcnt;
        k = 1; lat = -1; bcnt = 0;
        while (k <= 400) begin
            if (k == poke) begin
                ifc.i_usher = 1'b1; ifc.i_mode = 2'b00;
                ifc.i_address = 8'hFF; ifc.i_subaddress = 8'hEE; ifc.i_data = 8'h11;
            end else if (k == poke + 1) begin
                ifc.i_usher = 1'b0;
            end
            if (ifc.o_done) begin
                lat = k;
                break;
            end
            if (ifc.o_busy) bcnt++;
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_cycles"}, bcnt, exp_lat - 1);
        chk({tag, " busy_in_done"}, ifc.o_busy, 1'b0);
        chk({tag, " nack"}, ifc.o_nack, exp_nack);
        chk({tag, " o_data"}, ifc.o_data, exp_od);
        chk({tag, " protocol"}, proto_err, 0);
        model_events(m, a, s, dt, rv);
        chk({tag, " event_count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            chk($sformatf("%s event[%0d]", tag, i), ev_q[i], exp_q[i]);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] m, input logic [7:0] a, s, dt, rv,
                           input logic [2:0] mk, input int exp_lat, input logic exp_nack,
                           input logic [7:0] exp_od);
        @(negedge clk);
        start_cmd(m, a, s, dt, rv, mk);
        finish_cmd(tag, 0, exp_lat, exp_nack, exp_od, m, a, s, dt, rv);
        @(negedge clk);
        chk({tag, " done_pulse_len"}, ifc.o_done, 1'b0);
    endtask

    initial begin
        int viol;
        logic [1:0] m;
        logic [7:0] a, s, dt, rv;
        logic [2:0] mk, wm;

        reset_ = 1'b1;
        ifc.i_usher = 1'b0; ifc.i_mode = 2'b00;
        ifc.i_address = 8'h00; ifc.i_subaddress = 8'h00; ifc.i_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset o_busy", ifc.o_busy, 1'b0);
        chk("reset o_done", ifc.o_done, 1'b0);
        chk("reset o_data", ifc.o_data, 8'h00);
        chk("reset o_nack", ifc.o_nack, 1'b0);
        chk("reset sio_c", ifc.sio_c, 1'b1);
        chk("reset sio_d_o", ifc.sio_d_o, 1'b1);
        chk("reset sio_d_oe", ifc.sio_d_oe, 1'b0);
        reset_ = 1'b0;
        model_odata = 8'h00;

        vecs[0] = '{2'b00, 8'h42, 8'h12, 8'h80, 8'h00, 3'b000, 233, 1'b0, 8'h00};
        vecs[1] = '{2'b10, 8'h42, 8'h0A, 8'h00, 8'h76, 3'b000, 329, 1'b0, 8'h76};
        vecs[2] = '{2'b01, 8'h42, 8'h1C, 8'h00, 8'h00, 3'b111, 161, 1'b1, 8'h76};
        vecs[3] = '{2'b00, 8'h43, 8'h55, 8'hAA, 8'h00, 3'b000, 233, 1'b0, 8'h76};
        vecs[4] = '{2'b10, 8'h21, 8'hF0, 8'h00, 8'h81, 3'b100, 329, 1'b1, 8'h81};
        for (int i = 0; i < 5; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].mode, vecs[i].addr, vecs[i].sub,
                    vecs[i].data, vecs[i].rdval, vecs[i].mask, vecs[i].exp_lat,
                    vecs[i].exp_nack, vecs[i].exp_odata);
        model_odata = 8'h81;

        // Strobe mid-transfer with different inputs: ignored, latched copies used
        @(negedge clk);
        start_cmd(2'b01, 8'h42, 8'h1C, 8'h00, 8'h00, 3'b000);
        finish_cmd("ignore_busy", 50, 161, 1'b0, model_odata, 2'b01, 8'h42, 8'h1C, 8'h00, 8'h00);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.o_busy || ifc.o_done) viol++;
        end
        chk("ignore_busy no_extra_txn", viol, 0);

        // Reserved mode strobe in IDLE
        @(negedge clk);
        ev_q.delete();
        ifc.i_mode = 2'b11; ifc.i_usher = 1'b1;
        @(negedge clk);
        ifc.i_usher = 1'b0;
        viol = 0;
        repeat (20) begin
            if (ifc.o_busy || ifc.o_done || !ifc.sio_c || ifc.sio_d_oe) viol++;
            @(negedge clk);
        end
        chk("mode11 idle_lines", viol, 0);
        chk("mode11 events", ev_q.size(), 0);

        // Reset during the 5th sub-address bit
        @(negedge clk);
        start_cmd(2'b00, 8'h42, 8'h12, 8'h80, 8'h00, 3'b000);
        repeat (113) @(negedge clk);
        chk("midreset busy_before", ifc.o_busy, 1'b1);
        reset_ = 1'b1;
        @(negedge clk);
        chk("midreset sio_c", ifc.sio_c, 1'b1);
        chk("midreset sio_d_oe", ifc.sio_d_oe, 1'b0);
        chk("midreset o_busy", ifc.o_busy, 1'b0);
        chk("midreset o_data", ifc.o_data, 8'h00);
        reset_ = 1'b0;
        model_odata = 8'h00;
        run_cmd("after_reset", 2'b00, 8'h42, 8'h12, 8'h80, 8'h00, 3'b000, 233, 1'b0, 8'h00);

        // Back-to-back: second strobe lands in the DONE cycle of the first
        @(negedge clk);
        start_cmd(2'b00, 8'h60, 8'h01, 8'h02, 8'h00, 3'b000);
        finish_cmd("b2b_first", 0, 233, 1'b0, 8'h00, 2'b00, 8'h60, 8'h01, 8'h02, 8'h00);
        start_cmd(2'b01, 8'h60, 8'h33, 8'h00, 8'h00, 3'b000);
        finish_cmd("b2b_second", 0, 161, 1'b0, 8'h00, 2'b01, 8'h60, 8'h33, 8'h00, 8'h00);
        @(negedge clk);
        chk("b2b done_pulse_len", ifc.o_done, 1'b0);

        for (int i = 0; i < 8; i++) begin
            m  = 2'($urandom_range(0, 2));
            a  = 8'($urandom); s = 8'($urandom); dt = 8'($urandom); rv = 8'($urandom);
            mk = 3'($urandom);
            wm = (m == 2'b01) ? 3'b011 : 3'b111;
            if (m == 2'b10) model_odata = rv;
            run_cmd($sformatf("rand%0d", i), m, a, s, dt, rv, mk, model_lat(m),
                    |(mk & wm), model_odata);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
